// File: rtl/board_render_seq_pkg.sv
// Shared definitions for the board redraw sequencer: cell codes, FSM state
// encoding, screen coordinate widths and a small cell-code helper.
package board_render_seq_pkg;

    localparam int X_W = 9;
    localparam int Y_W = 8;

    typedef enum logic [1:0] {
        CELL_EMPTY  = 2'd0,
        CELL_BLACK  = 2'd1,
        CELL_WHITE  = 2'd2,
        CELL_CURSOR = 2'd3
    } cell_code_e;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_FETCH       = 3'd1,
        ST_FETCH_WAIT  = 3'd2,
        ST_LATCH       = 3'd3,
        ST_START       = 3'd4,
        ST_WAIT_RENDER = 3'd5,
        ST_NEXT        = 3'd6,
        ST_DONE        = 3'd7
    } seq_state_e;

    function automatic logic is_empty(input logic [1:0] code);
        return (code == CELL_EMPTY);
    endfunction

endpackage

// File: rtl/board_render_seq_grid_cursor.sv
// Row-major cell walker: col/row counters with accumulated screen origin and
// board RAM address, so no multiplier is needed.
module board_render_seq_grid_cursor
    import board_render_seq_pkg::*;
#(
    parameter int COLS     = 8,
    parameter int ROWS     = 8,
    parameter int CELL_W   = 28,
    parameter int CELL_H   = 28,
    parameter int ORIGIN_X = 0,
    parameter int ORIGIN_Y = 0,
    parameter int ADDR_B   = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rewind,
    input  logic              step,
    output logic [X_W-1:0]    base_x,
    output logic [Y_W-1:0]    base_y,
    output logic [ADDR_B-1:0] address,
    output logic              last
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [CW-1:0]     col_r;
    logic [RW-1:0]     row_r;
    logic [X_W-1:0]    base_x_r;
    logic [Y_W-1:0]    base_y_r;
    logic [ADDR_B-1:0] address_r;
    logic              col_end_s;
    logic              last_s;

    assign col_end_s = (col_r == CW'(COLS - 1));
    assign last_s    = col_end_s && (row_r == RW'(ROWS - 1));

    // Counter/accumulator update; the last cell wraps everything back to the origin.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col_r     <= '0;
            row_r     <= '0;
            base_x_r  <= X_W'(ORIGIN_X);
            base_y_r  <= Y_W'(ORIGIN_Y);
            address_r <= '0;
        end else if (rewind || (step && last_s)) begin
            col_r     <= '0;
            row_r     <= '0;
            base_x_r  <= X_W'(ORIGIN_X);
            base_y_r  <= Y_W'(ORIGIN_Y);
            address_r <= '0;
        end else if (step && col_end_s) begin
            col_r     <= '0;
            row_r     <= row_r + RW'(1);
            base_x_r  <= X_W'(ORIGIN_X);
            base_y_r  <= base_y_r + Y_W'(CELL_H);
            address_r <= address_r + ADDR_B'(1);
        end else if (step) begin
            col_r     <= col_r + CW'(1);
            base_x_r  <= base_x_r + X_W'(CELL_W);
            address_r <= address_r + ADDR_B'(1);
        end else begin
            col_r     <= col_r;
            row_r     <= row_r;
            base_x_r  <= base_x_r;
            base_y_r  <= base_y_r;
            address_r <= address_r;
        end
    end

    assign base_x  = base_x_r;
    assign base_y  = base_y_r;
    assign address = address_r;
    assign last    = last_s;

endmodule

// File: rtl/board_render_seq.sv
// Redraw sequencer: walks the board, fetches each cell code from sync RAM and
// issues one start_render/render_complete handshake per non-empty cell.
module board_render_seq
    import board_render_seq_pkg::*;
#(
    parameter int COLS       = 8,
    parameter int ROWS       = 8,
    parameter int CELL_W     = 28,
    parameter int CELL_H     = 28,
    parameter int ORIGIN_X   = 0,
    parameter int ORIGIN_Y   = 0,
    parameter int ADDR_B     = 6,
    parameter int SKIP_EMPTY = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              redraw,
    output logic [ADDR_B-1:0] board_address,
    input  logic [1:0]        board_data,
    output logic [1:0]        pic_sel,
    output logic [8:0]        base_x,
    output logic [7:0]        base_y,
    output logic              start_render,
    input  logic              render_complete,
    output logic              busy,
    output logic              done
);

    seq_state_e state_r;
    seq_state_e state_s;
    logic       pending_r;
    logic       pending_clr_s;
    logic       rewind_s;
    logic       step_s;
    logic       last_s;
    logic [1:0] pic_sel_r;
    logic       start_render_r;
    logic       busy_r;
    logic       done_r;

    board_render_seq_grid_cursor #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .CELL_W   (CELL_W),
        .CELL_H   (CELL_H),
        .ORIGIN_X (ORIGIN_X),
        .ORIGIN_Y (ORIGIN_Y),
        .ADDR_B   (ADDR_B)
    ) u_cursor (
        .clk     (clk),
        .resetn  (resetn),
        .rewind  (rewind_s),
        .step    (step_s),
        .base_x  (base_x),
        .base_y  (base_y),
        .address (board_address),
        .last    (last_s)
    );

    // Next-state and cursor control.
    always_comb begin
        state_s       = state_r;
        rewind_s      = 1'b0;
        step_s        = 1'b0;
        pending_clr_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (redraw) begin
                    state_s  = ST_FETCH;
                    rewind_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH:      state_s = ST_FETCH_WAIT;
            ST_FETCH_WAIT: state_s = ST_LATCH;
            ST_LATCH: begin
                if ((SKIP_EMPTY != 0) && is_empty(pic_sel_r)) begin
                    state_s = ST_NEXT;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_START:      state_s = ST_WAIT_RENDER;
            ST_WAIT_RENDER: begin
                if (render_complete) begin
                    state_s = ST_NEXT;
                end else begin
                    state_s = ST_WAIT_RENDER;
                end
            end
            ST_NEXT: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DONE: begin
                // A request arriving in this very cycle is honoured like a pending one.
                if (pending_r || redraw) begin
                    state_s       = ST_FETCH;
                    rewind_s      = 1'b1;
                    pending_clr_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, pending flag and registered renderer-facing outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r        <= ST_IDLE;
            pending_r      <= 1'b0;
            pic_sel_r      <= 2'd0;
            start_render_r <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            start_render_r <= (state_s == ST_START);
            busy_r         <= (state_s != ST_IDLE);
            done_r         <= (state_s == ST_DONE);
            if (pending_clr_s) begin
                pending_r <= 1'b0;
            end else if (redraw && (state_r != ST_IDLE)) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end
            if (state_r == ST_FETCH_WAIT) begin
                pic_sel_r <= board_data;
            end else begin
                pic_sel_r <= pic_sel_r;
            end
        end
    end

    assign pic_sel      = pic_sel_r;
    assign start_render = start_render_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: tb/tb_board_render_seq.sv
// Scoreboard bench for board_render_seq: sync board RAM and renderer models,
// expected transactions derived from the board contents with plain arithmetic.
module tb_board_render_seq;

    localparam int COLS = 8;
    localparam int ROWS = 8;
    localparam int CW   = 28;
    localparam int CH   = 28;
    localparam int OX   = 48;
    localparam int OY   = 8;

    logic       clk = 1'b0;
    logic       resetn;
    logic       redraw;
    logic [5:0] board_address;
    logic [1:0] board_data;
    logic [1:0] pic_sel;
    logic [8:0] base_x;
    logic [7:0] base_y;
    logic       start_render;
    logic       render_complete;
    logic       busy;
    logic       done;
    logic       rc_m = 1'b0;
    logic       rc_spur;

    logic [1:0] mem [64];

    typedef struct {
        bit         is_done;
        logic [1:0] pic;
        int         x;
        int         y;
        int         addr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   exp_done_total = 0;
    int   done_cnt = 0;
    int   start_cnt = 0;
    int   mon_last_addr = -1;
    int   lat_fixed = 10;
    int   cyc = 0;
    int   last_rc = -100;

    always #5 clk = ~clk;

    assign render_complete = rc_m | rc_spur;

    board_render_seq #(
        .ORIGIN_X (OX),
        .ORIGIN_Y (OY)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .redraw          (redraw),
        .board_address   (board_address),
        .board_data      (board_data),
        .pic_sel         (pic_sel),
        .base_x          (base_x),
        .base_y          (base_y),
        .start_render    (start_render),
        .render_complete (render_complete),
        .busy            (busy),
        .done            (done)
    );

    // Synchronous board RAM: one cycle read latency.
    always @(posedge clk) board_data <= mem[board_address];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (render_complete) last_rc <= cyc;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Expected result of one full pass over the current board contents.
    task automatic push_pass();
        exp_t e;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (mem[r*COLS+c] != 2'd0) begin
                    e.is_done = 1'b0;
                    e.pic     = mem[r*COLS+c];
                    e.x       = OX + c*CW;
                    e.y       = OY + r*CH;
                    e.addr    = r*COLS + c;
                    exp_q.push_back(e);
                end
            end
        end
        e = '{is_done: 1'b1, pic: 2'd0, x: 0, y: 0, addr: 0};
        exp_q.push_back(e);
        exp_done_total++;
    endtask

    // Renderer model: completes lat cycles after it sees start.
    initial begin : renderer
        int cnt = 0;
        forever begin
            @(negedge clk);
            rc_m = 1'b0;
            if (!resetn) cnt = 0;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) rc_m = 1'b1;
            end else if (start_render) begin
                cnt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 6));
            end
        end
    end

    // Monitor: pops the scoreboard on every start_render and done pulse.
    initial begin : monitor
        bit         prev_start = 1'b0;
        bit         in_wait = 1'b0;
        bit         ok;
        logic [1:0] h_pic;
        logic [8:0] h_x;
        logic [7:0] h_y;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_start = 1'b0;
                in_wait    = 1'b0;
            end else begin
                if (in_wait && (last_rc == cyc - 1)) in_wait = 1'b0;
                if (in_wait) begin
                    check("hold_pic", pic_sel, h_pic);
                    check("hold_x", base_x, h_x);
                    check("hold_y", base_y, h_y);
                end
                if (start_render) begin
                    start_cnt++;
                    mon_last_addr = board_address;
                    check("start_one_cycle", prev_start, 0);
                    check("start_gap", (cyc - last_rc >= 2), 1);
                    ok = (exp_q.size() > 0) && !exp_q[0].is_done;
                    check("start_expected", ok, 1);
                    if (ok) begin
                        e = exp_q.pop_front();
                        check("pic_sel", pic_sel, e.pic);
                        check("base_x", base_x, e.x);
                        check("base_y", base_y, e.y);
                        check("board_address", board_address, e.addr);
                    end
                    h_pic   = pic_sel;
                    h_x     = base_x;
                    h_y     = base_y;
                    in_wait = 1'b1;
                end
                if (done) begin
                    done_cnt++;
                    ok = (exp_q.size() > 0) && exp_q[0].is_done;
                    check("done_expected", ok, 1);
                    if (ok) e = exp_q.pop_front();
                end
                prev_start = start_render;
            end
        end
    end

    task automatic pulse_redraw();
        @(negedge clk);
        redraw = 1'b1;
        @(negedge clk);
        redraw = 1'b0;
    endtask

    task automatic wait_quiet();
        bit ok = 1'b0;
        for (int k = 0; k < 8000 && !ok; k++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) ok = 1'b1;
        end
        check("pass_finished", ok, 1);
    endtask

    task automatic check_reset_vals();
        check("rst_start", start_render, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", board_address, 0);
        check("rst_pic", pic_sel, 0);
        check("rst_base_x", base_x, OX);
        check("rst_base_y", base_y, OY);
    endtask

    // One pass with fixed renderer latency, checking exact duration and busy.
    task automatic run_timed(input int lat);
        int exp_cyc = 1;
        int n = 0;
        bit busy_ok = 1'b1;
        bit seen = 1'b0;
        lat_fixed = lat;
        for (int i = 0; i < 64; i++) exp_cyc += (mem[i] == 2'd0) ? 4 : 5 + lat;
        push_pass();
        @(negedge clk);
        redraw = 1'b1;
        for (int k = 0; k < 4000 && !seen; k++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            redraw = 1'b0;
            if (done) seen = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        check("timed_done_seen", seen, 1);
        check("timed_cycles", n, exp_cyc);
        check("timed_busy_high", busy_ok, 1);
        wait_quiet();
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) mem[i] = 2'($urandom_range(0, 3));
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int s0;
        int d0;
        bit seen;
        resetn  = 1'b1;
        redraw  = 1'b0;
        rc_spur = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 2'd0;
        #3 resetn = 1'b0;
        #1 check_reset_vals();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // All cells empty: no starts, 4 cycles per cell.
        s0 = start_cnt;
        run_timed(10);
        check("empty_starts", start_cnt - s0, 0);

        // Two occupied corner cells, renderer latency 10.
        mem[0]  = 2'd1;
        mem[63] = 2'd2;
        s0 = start_cnt;
        run_timed(10);
        check("corner_starts", start_cnt - s0, 2);

        // All cells BLACK, random renderer latency.
        for (int i = 0; i < 64; i++) mem[i] = 2'd1;
        lat_fixed = 0;
        s0 = start_cnt;
        push_pass();
        pulse_redraw();
        wait_quiet();
        check("black_starts", start_cnt - s0, 64);

        // Three redraw pulses mid-pass merge into one extra pass.
        fill_random();
        d0 = done_cnt;
        push_pass();
        pulse_redraw();
        repeat (40) @(negedge clk);
        push_pass();
        for (int k = 0; k < 3; k++) begin
            pulse_redraw();
            repeat (20) @(negedge clk);
        end
        wait_quiet();
        check("merged_dones", done_cnt - d0, 2);

        // Redraw raised in the DONE cycle starts another pass.
        fill_random();
        d0 = done_cnt;
        push_pass();
        pulse_redraw();
        seen = 1'b0;
        for (int k = 0; k < 4000 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_cycle_seen", seen, 1);
        redraw = 1'b1;
        push_pass();
        @(negedge clk);
        redraw = 1'b0;
        wait_quiet();
        check("done_cycle_dones", done_cnt - d0, 2);

        // Reset while waiting for the renderer on cell 20.
        for (int i = 0; i < 64; i++) mem[i] = 2'd1;
        lat_fixed = 4;
        push_pass();
        pulse_redraw();
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge clk);
            if (mon_last_addr == 20) seen = 1'b1;
        end
        check("cell20_reached", seen, 1);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1 check_reset_vals();
        exp_q.delete();
        exp_done_total--;
        repeat (3) @(negedge clk);
        check("no_done_on_reset", done_cnt, exp_done_total);
        #2 resetn = 1'b1;
        fill_random();
        mem[0] = 2'd2;
        lat_fixed = 0;
        push_pass();
        pulse_redraw();
        wait_quiet();

        // Spurious render_complete in IDLE and in FETCH.
        @(negedge clk);
        rc_spur = 1'b1;
        @(negedge clk);
        rc_spur = 1'b0;
        repeat (2) @(negedge clk);
        check("spur_idle_busy", busy, 0);
        check("spur_idle_addr", board_address, 0);
        fill_random();
        mem[0] = 2'd3;
        mem[1] = 2'd1;
        push_pass();
        @(negedge clk);
        redraw = 1'b1;
        @(negedge clk);
        redraw  = 1'b0;
        rc_spur = 1'b1;
        @(negedge clk);
        rc_spur = 1'b0;
        wait_quiet();

        // A few random passes.
        for (int t = 0; t < 3; t++) begin
            fill_random();
            push_pass();
            pulse_redraw();
            wait_quiet();
        end

        check("total_dones", done_cnt, exp_done_total);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
